// File: rtl/mem_bank_arbiter.sv
// mem_bank_arbiter: round-robin arbiter sharing one single-port memory bank
// between NUM_REQ requesters. It grants one access per cycle, registers the
// granted access onto the bank port and routes each read's data back to the
// requester that issued it, once the bank's fixed read latency has elapsed.

package mem_bank_arbiter_pkg;
    typedef logic [1:0] DataWidth_t;
    typedef logic [3:0] FxFormat_t;
endpackage

module mem_bank_arbiter
    import mem_bank_arbiter_pkg::*;
#(
    parameter int NUM_REQ  = 4,
    parameter int ADDR_W   = 16,
    parameter int DATA_W   = 16,
    parameter int READ_LAT = 1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_REQ-1:0]              req_en,
    input  logic [NUM_REQ-1:0]              req_we,
    input  logic [NUM_REQ-1:0][ADDR_W-1:0]  req_addr,
    input  logic [NUM_REQ-1:0][DATA_W-1:0]  req_wdata,
    input  DataWidth_t [NUM_REQ-1:0]        req_width,
    input  FxFormat_t  [NUM_REQ-1:0]        req_format,
    output logic [NUM_REQ-1:0]              req_gnt,
    output logic [NUM_REQ-1:0]              rd_valid,
    output logic [DATA_W-1:0]               rd_data,
    output logic                            bank_en,
    output logic                            bank_chip_en,
    output logic [ADDR_W-1:0]               bank_addr,
    output logic [DATA_W-1:0]               bank_wdata,
    output DataWidth_t                      bank_width,
    output FxFormat_t                       bank_format,
    input  logic [DATA_W-1:0]               bank_rdata
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int LAST  = NUM_REQ - 1;

    logic [PTR_W-1:0] ptr_r;
    logic [PTR_W-1:0] win_s;
    logic [PTR_W-1:0] ptr_nxt_s;
    logic             found_s;
    logic             grant_s;
    logic             rd_grant_s;

    // Tracking pipe: stage 0 is loaded on the grant edge, so stage READ_LAT
    // lines up with the cycle in which bank_rdata carries that read's data.
    logic [READ_LAT:0]             trk_valid_r;
    logic [READ_LAT:0][PTR_W-1:0]  trk_id_r;

    // Round-robin search starting at the priority pointer; grant is suppressed during reset.
    always_comb begin
        int idx;
        idx     = 0;
        found_s = 1'b0;
        win_s   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(ptr_r) + k >= NUM_REQ) ? (int'(ptr_r) + k - NUM_REQ) : (int'(ptr_r) + k);
            if (!found_s && req_en[idx]) begin
                found_s = 1'b1;
                win_s   = PTR_W'(idx);
            end else begin
                found_s = found_s;
            end
        end
        grant_s    = found_s && !rst;
        rd_grant_s = grant_s && !req_we[win_s];
        ptr_nxt_s  = (win_s == PTR_W'(LAST)) ? '0 : (win_s + PTR_W'(1));
        req_gnt    = '0;
        if (grant_s) begin
            req_gnt[win_s] = 1'b1;
        end else begin
            req_gnt = '0;
        end
    end

    // Pointer update and registered bank-side access for the granted requester.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_r        <= '0;
            bank_en      <= 1'b0;
            bank_chip_en <= 1'b0;
            bank_addr    <= '0;
            bank_wdata   <= '0;
            bank_width   <= '0;
            bank_format  <= '0;
        end else if (grant_s) begin
            ptr_r        <= ptr_nxt_s;
            bank_en      <= 1'b1;
            bank_chip_en <= req_we[win_s];
            bank_addr    <= req_addr[win_s];
            bank_wdata   <= req_wdata[win_s];
            bank_width   <= req_width[win_s];
            bank_format  <= req_format[win_s];
        end else begin
            bank_en      <= 1'b0;
            bank_chip_en <= 1'b0;
        end
    end

    // Shift in-flight read tags through the bank latency; reset drops them all.
    always_ff @(posedge clk) begin
        if (rst) begin
            trk_valid_r <= '0;
            trk_id_r    <= '0;
        end else begin
            trk_valid_r <= {trk_valid_r[READ_LAT-1:0], rd_grant_s};
            trk_id_r    <= {trk_id_r[READ_LAT-1:0], win_s};
        end
    end

    // Capture bank data at the pipe tail and strobe it to the issuing requester.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_valid <= '0;
            rd_data  <= '0;
        end else begin
            rd_valid <= '0;
            if (trk_valid_r[READ_LAT]) begin
                rd_valid[trk_id_r[READ_LAT]] <= 1'b1;
                rd_data                      <= bank_rdata;
            end else begin
                rd_data <= rd_data;
            end
        end
    end

endmodule

// File: tb/tb_mem_bank_arbiter.sv
// Scoreboard bench for mem_bank_arbiter: a driver issues requests and pushes
// expected grants, bank accesses and read returns into queues; a monitor on
// the falling edge pops and compares them against the DUT outputs.
module tb_mem_bank_arbiter;
    import mem_bank_arbiter_pkg::*;

    localparam int N  = 4;
    localparam int AW = 16;
    localparam int DW = 16;
    localparam int RL = 1;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic [N-1:0]           req_en = '0;
    logic [N-1:0]           req_we = '0;
    logic [N-1:0][AW-1:0]   req_addr = '0;
    logic [N-1:0][DW-1:0]   req_wdata = '0;
    DataWidth_t [N-1:0]     req_width = '0;
    FxFormat_t  [N-1:0]     req_format = '0;
    logic [N-1:0]           req_gnt;
    logic [N-1:0]           rd_valid;
    logic [DW-1:0]          rd_data;
    logic                   bank_en;
    logic                   bank_chip_en;
    logic [AW-1:0]          bank_addr;
    logic [DW-1:0]          bank_wdata;
    DataWidth_t             bank_width;
    FxFormat_t              bank_format;
    logic [DW-1:0]          bank_rdata = '0;

    always #5 clk = ~clk;

    mem_bank_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .READ_LAT(RL)) dut (
        .clk(clk), .rst(rst),
        .req_en(req_en), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_width(req_width), .req_format(req_format),
        .req_gnt(req_gnt), .rd_valid(rd_valid), .rd_data(rd_data),
        .bank_en(bank_en), .bank_chip_en(bank_chip_en), .bank_addr(bank_addr),
        .bank_wdata(bank_wdata), .bank_width(bank_width), .bank_format(bank_format),
        .bank_rdata(bank_rdata)
    );

    function automatic logic [15:0] init_val(int a);
        logic [15:0] v;
        v = (a == 32'h40) ? 16'h1234 : ((16'(a) * 16'h0101) ^ 16'h5A5A);
        return v;
    endfunction

    // Behavioural single-port bank with READ_LAT = 1 (data one cycle after bank_en).
    logic [15:0] bmem [256];
    bit          bwr  [256];
    always @(posedge clk) begin
        if (bank_en) begin
            if (bank_chip_en) begin
                bmem[int'(bank_addr[7:0])] <= bank_wdata;
                bwr[int'(bank_addr[7:0])]  <= 1'b1;
            end else begin
                bank_rdata <= bwr[int'(bank_addr[7:0])] ? bmem[int'(bank_addr[7:0])]
                                                         : init_val(int'(bank_addr[7:0]));
            end
        end
    end

    typedef struct { int cyc; logic [N-1:0] gnt; } gexp_t;
    typedef struct { int cyc; bit en; bit chip; logic [AW-1:0] addr; logic [DW-1:0] wd;
                     DataWidth_t w; FxFormat_t f; } bexp_t;
    typedef struct { int cyc; int id; logic [DW-1:0] data; } rexp_t;

    gexp_t gnt_q[$];
    bexp_t bank_q[$];
    rexp_t rd_q[$];

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cycle %0d: got %h, expected %h", nm, cyc, act, exp);
        end
    endtask

    // Reference state: request slots, round-robin pointer, last bank fields, memory image.
    bit          pend  [N];
    bit          we_f  [N];
    logic [15:0] addr_f[N];
    logic [15:0] wd_f  [N];
    DataWidth_t  w_f   [N];
    FxFormat_t   f_f   [N];
    int          mptr = 0;
    bexp_t       last;
    logic [15:0] ref_mem [256];
    bit          ref_wr  [256];

    task automatic set_req(int i, bit we, logic [15:0] a, logic [15:0] d, DataWidth_t w, FxFormat_t f);
        pend[i] = 1'b1; we_f[i] = we; addr_f[i] = a; wd_f[i] = d; w_f[i] = w; f_f[i] = f;
    endtask

    task automatic step(bit r, int p_start, int p_wd);
        int w;
        int j;
        int a;
        bexp_t b;
        rexp_t e;
        @(posedge clk);
        cyc++;
        #1;
        for (int i = 0; i < N; i++) begin
            if (pend[i] && int'($urandom_range(99)) < p_wd) pend[i] = 1'b0;
            if (!pend[i] && int'($urandom_range(99)) < p_start)
                set_req(i, 1'($urandom_range(1)), 16'($urandom_range(255)), 16'($urandom),
                        DataWidth_t'($urandom_range(3)), FxFormat_t'($urandom_range(15)));
        end
        rst = r;
        for (int i = 0; i < N; i++) begin
            req_en[i] = pend[i]; req_we[i] = we_f[i]; req_addr[i] = addr_f[i];
            req_wdata[i] = wd_f[i]; req_width[i] = w_f[i]; req_format[i] = f_f[i];
        end
        w = -1;
        for (int k = 0; k < N; k++) begin
            j = (mptr + k) % N;
            if (w < 0 && pend[j]) w = j;
        end
        if (r) w = -1;
        gnt_q.push_back('{cyc, (w >= 0) ? N'(1 << w) : N'(0)});
        if (r) begin
            mptr = 0;
            last = '{0, 1'b0, 1'b0, '0, '0, '0, '0};
            while (rd_q.size() > 0 && rd_q[$].cyc > cyc) void'(rd_q.pop_back());
            b = last;
        end else if (w >= 0) begin
            last = '{0, 1'b0, 1'b0, addr_f[w], wd_f[w], w_f[w], f_f[w]};
            b = last; b.en = 1'b1; b.chip = we_f[w];
            mptr = (w + 1) % N;
            a = int'(addr_f[w][7:0]);
            if (we_f[w]) begin
                ref_mem[a] = wd_f[w]; ref_wr[a] = 1'b1;
            end else begin
                e = '{cyc + 2 + RL, w, ref_wr[a] ? ref_mem[a] : init_val(a)};
                rd_q.push_back(e);
            end
            pend[w] = 1'b0;
        end else begin
            b = last;
        end
        b.cyc = cyc + 1;
        bank_q.push_back(b);
    endtask

    // Monitor: compare grants, bank port and read returns against the queued expectations.
    gexp_t m_g;
    bexp_t m_b;
    rexp_t m_r;
    always @(negedge clk) begin
        if (gnt_q.size() > 0 && gnt_q[0].cyc == cyc) begin
            m_g = gnt_q.pop_front();
            chk("req_gnt", 32'(req_gnt), 32'(m_g.gnt));
        end
        if (bank_q.size() > 0 && bank_q[0].cyc == cyc) begin
            m_b = bank_q.pop_front();
            chk("bank_en", 32'(bank_en), 32'(m_b.en));
            chk("bank_chip_en", 32'(bank_chip_en), 32'(m_b.chip));
            chk("bank_addr", 32'(bank_addr), 32'(m_b.addr));
            chk("bank_wdata", 32'(bank_wdata), 32'(m_b.wd));
            chk("bank_width", 32'(bank_width), 32'(m_b.w));
            chk("bank_format", 32'(bank_format), 32'(m_b.f));
        end
        if (rd_q.size() > 0 && rd_q[0].cyc == cyc) begin
            m_r = rd_q.pop_front();
            chk("rd_valid", 32'(rd_valid), 32'(1 << m_r.id));
            chk("rd_data", 32'(rd_data), 32'(m_r.data));
        end else begin
            chk("rd_valid_idle", 32'(rd_valid), 32'h0);
        end
    end

    initial begin
        last = '{0, 1'b0, 1'b0, '0, '0, '0, '0};
        // Reset held 3 cycles with every requester asking.
        for (int i = 0; i < N; i++) set_req(i, 1'b0, 16'(i * 3), 16'h0, 2'd0, 4'd0);
        repeat (3) step(1'b1, 0, 0);
        // Full contention: every slot re-requests immediately after its grant.
        step(1'b0, 100, 0);
        chk("rd_data_after_reset", 32'(rd_data), 32'h0);
        repeat (7) step(1'b0, 100, 0);
        repeat (6) step(1'b0, 0, 0);
        // Read round-trip from requester 2 at 0x0040.
        set_req(2, 1'b0, 16'h0040, 16'h0, 2'd1, 4'd3);
        repeat (6) step(1'b0, 0, 0);
        // Write from requester 1, then read it back.
        set_req(1, 1'b1, 16'h0010, 16'hBEEF, 2'd2, 4'd5);
        step(1'b0, 0, 0);
        set_req(0, 1'b0, 16'h0010, 16'h0, 2'd0, 4'd0);
        repeat (6) step(1'b0, 0, 0);
        // Pointer wrap: grant 3, then 0 and 3 together -> 0 then 3.
        set_req(3, 1'b0, 16'h0005, 16'h0, 2'd0, 4'd1);
        step(1'b0, 0, 0);
        set_req(0, 1'b0, 16'h0006, 16'h0, 2'd0, 4'd2);
        set_req(3, 1'b0, 16'h0007, 16'h0, 2'd0, 4'd3);
        repeat (6) step(1'b0, 0, 0);
        // Reset mid-flight: two reads, reset the cycle after the second grant.
        set_req(0, 1'b0, 16'h0020, 16'h0, 2'd0, 4'd0);
        step(1'b0, 0, 0);
        set_req(1, 1'b0, 16'h0021, 16'h0, 2'd0, 4'd0);
        step(1'b0, 0, 0);
        step(1'b1, 0, 0);
        repeat (6) step(1'b0, 0, 0);
        // Randomized traffic with withdrawals and occasional resets.
        for (int c = 0; c < 800; c++)
            step(int'($urandom_range(99)) < 2, 45, 8);
        for (int i = 0; i < N; i++) pend[i] = 1'b0;
        repeat (10) step(1'b0, 0, 0);
        @(negedge clk);
        #1;
        chk("reads_outstanding", 32'(rd_q.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
